// File: rtl/port_out_fifo_if.sv
// Byte handshake between switch fabric, egress FIFO and output-port consumer.
// drop_cnt/rd_cnt exist only when PORT_OUT_STATS_EN is defined.
interface port_out_fifo_if #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  logic [7:0]       wr_data;
  logic             wr_en;
  logic             full;
  logic [CNT_W-1:0] level;
  logic [7:0]       data;
  logic             ready;
  logic             read;
`ifdef PORT_OUT_STATS_EN
  logic [7:0]       drop_cnt;
  logic [15:0]      rd_cnt;
`endif

  // FIFO side of the port
  modport fifo (
    input  wr_data, wr_en, read,
    output full, level, data, ready
`ifdef PORT_OUT_STATS_EN
    , output drop_cnt, rd_cnt
`endif
  );

  // Fabric writer plus port consumer
  modport master (
    output wr_data, wr_en, read,
    input  full, level, data, ready
`ifdef PORT_OUT_STATS_EN
    , input drop_cnt, rd_cnt
`endif
  );
endinterface

// File: rtl/port_out_fifo.sv
// Show-ahead egress byte FIFO for one switch output port.
// Optional drop/pop statistics counters are compiled in with PORT_OUT_STATS_EN.
module port_out_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  port_out_fifo_if.fifo port
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] level_q, level_d;
  logic [7:0]       data_q, data_d;
  logic             ready_q, ready_d;
  logic             full_q, full_d;
  logic             push, pop;

  always_comb begin
    pop     = port.read && ready_q;
    push    = port.wr_en && (!full_q || pop);
    wptr_d  = push ? PTR_W'(wptr_q + 1'b1) : wptr_q;
    rptr_d  = pop  ? PTR_W'(rptr_q + 1'b1) : rptr_q;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = CNT_W'(level_q + 1'b1);
      2'b01:   level_d = CNT_W'(level_q - 1'b1);
      default: level_d = level_q;
    endcase
    ready_d = (level_d != '0);
    full_d  = (level_d == CNT_W'(DEPTH));
    // New head may be the byte being written this cycle; forward it past the RAM.
    data_d  = data_q;
    if (ready_d) begin
      if (push && (wptr_q == rptr_d))
        data_d = port.wr_data;
      else
        data_d = mem_q[rptr_d];
    end
  end

  // Storage: payload only, never reset
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wptr_q] <= port.wr_data;
  end

  // Control and registered head
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      full_q  <= full_d;
    end
  end

  assign port.data  = data_q;
  assign port.ready = ready_q;
  assign port.full  = full_q;
  assign port.level = level_q;

`ifdef PORT_OUT_STATS_EN
  logic [7:0]  drop_cnt_q;
  logic [15:0] rd_cnt_q;

  // Statistics: drops saturate, pops wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= 8'h00;
      rd_cnt_q   <= 16'h0000;
    end else begin
      if (port.wr_en && !push && (drop_cnt_q != 8'hFF))
        drop_cnt_q <= drop_cnt_q + 8'h01;
      if (pop)
        rd_cnt_q <= rd_cnt_q + 16'h0001;
    end
  end

  assign port.drop_cnt = drop_cnt_q;
  assign port.rd_cnt   = rd_cnt_q;
`endif
endmodule

// File: tb/tb_port_out_fifo.sv
// Self-checking bench for port_out_fifo: vector table plus scoreboarded sequences.
module tb_port_out_fifo;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  port_out_fifo_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  port_out_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .port  (bus.fifo)
  );

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       e_ready;
    logic [7:0] e_data;
    logic [4:0] e_level;
    logic       e_full;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] q [$];
  int         n_total = 0;
  int         n_pass  = 0;
  int         n_pops  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.read    = 1'b0;
  endtask

  initial begin
    int lvl, sent, got;
    logic wr, rd;
    logic [7:0] b;

    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[3] = '{1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 5'd1, 1'b0};
    vecs[4] = '{1'b1, 8'h22, 1'b1, 1'b1, 8'h22, 5'd1, 1'b0};
    vecs[5] = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h22, 5'd2, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 5'd1, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};

    idle_in();
    #1 reset = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_full",  32'(bus.full),  32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_data",  32'(bus.data),  32'h00);
`ifdef PORT_OUT_STATS_EN
    chk("rst_drop",  32'(bus.drop_cnt), 32'd0);
    chk("rst_rdcnt", 32'(bus.rd_cnt),   32'd0);
`endif
    tick();
    reset = 1'b0;

    // Idle with read held: nothing may change
    bus.read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_ready", 32'(bus.ready), 32'd0);
      chk("idle_level", 32'(bus.level), 32'd0);
    end
    chk("idle_data", 32'(bus.data), 32'h00);
    chk("idle_full", 32'(bus.full), 32'd0);
    idle_in();

    for (int i = 0; i < 8; i++) begin
      bus.wr_en   = vecs[i].wr;
      bus.wr_data = vecs[i].wd;
      bus.read    = vecs[i].rd;
      tick();
      chk($sformatf("vec%0d_ready", i), 32'(bus.ready), 32'(vecs[i].e_ready));
      chk($sformatf("vec%0d_level", i), 32'(bus.level), 32'(vecs[i].e_level));
      chk($sformatf("vec%0d_full", i),  32'(bus.full),  32'(vecs[i].e_full));
      if (vecs[i].e_ready)
        chk($sformatf("vec%0d_data", i), 32'(bus.data), 32'(vecs[i].e_data));
    end
    idle_in();

    // Fill to FULL, then two writes that must be dropped
    q.delete();
    for (int i = 1; i <= DEPTH; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(i);
      q.push_back(8'(i));
      tick();
    end
    bus.wr_data = 8'hEE;
    tick();
    bus.wr_data = 8'hEF;
    tick();
    idle_in();
    chk("fill_full",  32'(bus.full),  32'd1);
    chk("fill_level", 32'(bus.level), 32'd16);
    chk("fill_head",  32'(bus.data),  32'h01);
`ifdef PORT_OUT_STATS_EN
    chk("fill_drop", 32'(bus.drop_cnt), 32'd2);
`endif

    // Write and pop together while FULL
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h77;
    bus.read    = 1'b1;
    b = q.pop_front();
    chk("fullrw_head", 32'(bus.data), 32'(b));
    q.push_back(8'h77);
    tick();
    idle_in();
    chk("fullrw_level", 32'(bus.level), 32'd16);
    chk("fullrw_full",  32'(bus.full),  32'd1);
`ifdef PORT_OUT_STATS_EN
    chk("fullrw_drop", 32'(bus.drop_cnt), 32'd2);
`endif

    bus.read = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      b = q.pop_front();
      chk("drain_ready", 32'(bus.ready), 32'd1);
      chk("drain_data",  32'(bus.data),  32'(b));
      tick();
    end
    idle_in();
    chk("drain_ready_end", 32'(bus.ready), 32'd0);
    chk("drain_level_end", 32'(bus.level), 32'd0);
    chk("drain_full_end",  32'(bus.full),  32'd0);

    // Async reset between edges at level 5
    for (int i = 0; i < 5; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h50 + i);
      tick();
    end
    idle_in();
    chk("pre_rst_level", 32'(bus.level), 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("arst_ready", 32'(bus.ready), 32'd0);
    chk("arst_level", 32'(bus.level), 32'd0);
    chk("arst_full",  32'(bus.full),  32'd0);
`ifdef PORT_OUT_STATS_EN
    chk("arst_drop",  32'(bus.drop_cnt), 32'd0);
`endif
    #2 reset = 1'b0;
    q.delete();
    n_pops = 0;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h3C;
    tick();
    idle_in();
    chk("post_rst_ready", 32'(bus.ready), 32'd1);
    chk("post_rst_data",  32'(bus.data),  32'h3C);
    chk("post_rst_level", 32'(bus.level), 32'd1);
    bus.read = 1'b1;
    tick();
    n_pops++;
    idle_in();
    chk("post_rst_empty", 32'(bus.ready), 32'd0);

    // Streaming with wrap-around, level kept within 1..3
    lvl = 0; sent = 0; got = 0;
    for (int cyc = 0; cyc < 400 && got < 40; cyc++) begin
      wr = (sent < 40) && (lvl < 3);
      rd = (lvl > 0) && ((lvl == 3) || (sent == 40) || ($urandom_range(0, 1) == 1));
      bus.wr_en = wr;
      bus.read  = rd;
      if (rd) begin
        b = q.pop_front();
        chk("stream_data", 32'(bus.data), 32'(b));
        got++;
        n_pops++;
      end
      if (wr) begin
        b = 8'($urandom_range(0, 255));
        bus.wr_data = b;
        q.push_back(b);
        sent++;
      end
      tick();
      lvl = lvl + int'(wr) - int'(rd);
      chk("stream_level", 32'(bus.level), 32'(lvl));
    end
    idle_in();
    chk("stream_count", 32'(got), 32'd40);
    chk("stream_empty", 32'(bus.ready), 32'd0);
`ifdef PORT_OUT_STATS_EN
    chk("stream_rdcnt", 32'(bus.rd_cnt), 32'(n_pops));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
